// File: rtl/sched_pkg.sv
// Shared types and constants for the random-order asynchronous network scheduler.
package sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        PROBE,
        ROUND_END,
        DONE
    } sched_state_e;

    localparam int LFSR_W = 16;
    // Feedback taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 16'h0001;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0.
// A zero seed is replaced so the register can never lock up at all-zeros.
module lfsr16
    import sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr_d, lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == '0) ? LFSR_ZERO_SUB : seed;
        end else if (advance) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/random_order_scheduler.sv
// Runs network_logic under random-order asynchronous semantics: each round updates every
// non-frozen element once, in LFSR order, always using next-state of the live register.
module random_order_scheduler #(
    parameter int RULES  = 61,
    parameter int IDX_W  = $clog2(RULES),
    parameter int RND_W  = 16,
    parameter int LFSR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [RULES-1:0]  init_state,
    input  logic [LFSR_W-1:0] seed,
    input  logic [RND_W-1:0]  num_rounds,
    input  logic              stop_on_steady,
    input  logic [RULES-1:0]  freeze_mask,
    output logic [RULES-1:0]  net_cur,
    input  logic [RULES-1:0]  net_next,
    output logic              busy,
    output logic              done,
    output logic              steady,
    output logic              round_valid,
    output logic [RND_W-1:0]  rounds_done,
    output logic              upd_valid,
    output logic [IDX_W-1:0]  upd_idx
);
    import sched_pkg::*;

    sched_state_e      state_d, state_q;
    logic [RULES-1:0]  net_d, net_q;
    logic [RULES-1:0]  mask_d, mask_q;
    logic [RULES-1:0]  frz_d, frz_q;
    logic [RND_W-1:0]  nr_d, nr_q;
    logic [RND_W-1:0]  rounds_d, rounds_q;
    logic [IDX_W-1:0]  idx_d, idx_q;
    logic              sos_d, sos_q;
    logic              changed_d, changed_q;
    logic              steady_d, steady_q;

    logic              lfsr_load, lfsr_adv;
    logic [LFSR_W-1:0] lfsr_val;
    logic [IDX_W-1:0]  lfsr_v, pick_idx;
    logic [RND_W-1:0]  rounds_inc;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .seed    (seed),
        .advance (lfsr_adv),
        .value   (lfsr_val)
    );

    // Single fold into range is enough since 2^IDX_W < 2*RULES
    assign lfsr_v     = lfsr_val[IDX_W-1:0];
    assign pick_idx   = (32'(lfsr_v) >= RULES) ? IDX_W'(32'(lfsr_v) - RULES) : lfsr_v;
    assign rounds_inc = rounds_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        net_d       = net_q;
        mask_d      = mask_q;
        frz_d       = frz_q;
        nr_d        = nr_q;
        rounds_d    = rounds_q;
        idx_d       = idx_q;
        sos_d       = sos_q;
        changed_d   = changed_q;
        steady_d    = steady_q;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;
        upd_valid   = 1'b0;
        round_valid = 1'b0;
        done        = 1'b0;

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        net_d     = init_state;
                        nr_d      = num_rounds;
                        sos_d     = stop_on_steady;
                        frz_d     = freeze_mask;
                        mask_d    = freeze_mask;
                        changed_d = 1'b0;
                        rounds_d  = '0;
                        steady_d  = 1'b0;
                        lfsr_load = 1'b1;
                        state_d   = (num_rounds == '0) ? DONE : PICK;
                    end
                end
                PICK: begin
                    if (&mask_q) begin
                        state_d = ROUND_END;
                    end else begin
                        idx_d    = pick_idx;
                        lfsr_adv = 1'b1;
                        state_d  = PROBE;
                    end
                end
                PROBE: begin
                    // Linear probe forward to the next element not yet updated this round
                    if (mask_q[idx_q]) begin
                        idx_d = (32'(idx_q) == RULES - 1) ? '0 : idx_q + 1'b1;
                    end else begin
                        net_d[idx_q]  = net_next[idx_q];
                        mask_d[idx_q] = 1'b1;
                        changed_d     = changed_q | (net_next[idx_q] != net_q[idx_q]);
                        upd_valid     = 1'b1;
                        state_d       = PICK;
                    end
                end
                ROUND_END: begin
                    rounds_d    = rounds_inc;
                    round_valid = 1'b1;
                    if (sos_q && !changed_q) begin
                        steady_d = 1'b1;
                        state_d  = DONE;
                    end else if (rounds_inc == nr_q) begin
                        state_d = DONE;
                    end else begin
                        mask_d    = frz_q;
                        changed_d = 1'b0;
                        state_d   = PICK;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            net_q     <= '0;
            mask_q    <= '0;
            frz_q     <= '0;
            nr_q      <= '0;
            rounds_q  <= '0;
            idx_q     <= '0;
            sos_q     <= 1'b0;
            changed_q <= 1'b0;
            steady_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            net_q     <= net_d;
            mask_q    <= mask_d;
            frz_q     <= frz_d;
            nr_q      <= nr_d;
            rounds_q  <= rounds_d;
            idx_q     <= idx_d;
            sos_q     <= sos_d;
            changed_q <= changed_d;
            steady_q  <= steady_d;
        end
    end

    assign net_cur     = net_q;
    assign busy        = (state_q != IDLE);
    assign steady      = steady_q;
    assign rounds_done = rounds_q;
    assign upd_idx     = upd_valid ? idx_q : '0;

endmodule

// File: tb/tb_random_order_scheduler.sv
// Bench for random_order_scheduler: two instances (RULES=4 and RULES=5) driven by directed
// and randomized runs, checked against a round-by-round reference model.
module tb_random_order_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, abort = 1'b0, start4 = 1'b0, start5 = 1'b0, sos = 1'b0;
    logic [15:0] seed = '0, nr = '0;
    logic [7:0]  init_s = '0, frz_s = '0;
    int          mode = 0, sel = 0;
    int          vectors = 0, miscompares = 0;

    logic [3:0]  cur4, nxt4;
    logic [4:0]  cur5, nxt5;
    logic        busy4, done4, steady4, rv4, upd4;
    logic        busy5, done5, steady5, rv5, upd5;
    logic [15:0] rd4, rd5;
    logic [1:0]  idx4;
    logic [2:0]  idx5;
    logic [7:0]  n4w, n5w;

    int got_q[$], exp_q[$];
    int rv_cnt = 0, done_cnt = 0;

    // Network stubs: 0 identity, 1 inverter, 2 chain (bit0 <- 1), 3 nonlinear mix
    function automatic logic [7:0] stub(int md, logic [7:0] s, int r);
        logic [7:0] n = '0;
        for (int i = 0; i < r; i++) begin
            case (md)
                0: n[i] = s[i];
                1: n[i] = ~s[i];
                2: n[i] = (i == 0) ? 1'b1 : s[(i + 7) % 8];
                default: n[i] = s[(i + 1) % r] ^ (s[(i + 2) % r] & s[i]);
            endcase
        end
        return n;
    endfunction

    always_comb begin
        n4w = stub(mode, {4'b0, cur4}, 4);
        n5w = stub(mode, {3'b0, cur5}, 5);
    end
    assign nxt4 = n4w[3:0];
    assign nxt5 = n5w[4:0];

    random_order_scheduler #(.RULES(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .abort(abort),
        .init_state(init_s[3:0]), .seed(seed), .num_rounds(nr), .stop_on_steady(sos),
        .freeze_mask(frz_s[3:0]), .net_cur(cur4), .net_next(nxt4), .busy(busy4),
        .done(done4), .steady(steady4), .round_valid(rv4), .rounds_done(rd4),
        .upd_valid(upd4), .upd_idx(idx4)
    );

    random_order_scheduler #(.RULES(5)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .abort(abort),
        .init_state(init_s[4:0]), .seed(seed), .num_rounds(nr), .stop_on_steady(sos),
        .freeze_mask(frz_s[4:0]), .net_cur(cur5), .net_next(nxt5), .busy(busy5),
        .done(done5), .steady(steady5), .round_valid(rv5), .rounds_done(rd5),
        .upd_valid(upd5), .upd_idx(idx5)
    );

    always @(negedge clk) begin
        if (sel == 0 ? upd4 : upd5) got_q.push_back(sel == 0 ? int'(idx4) : int'(idx5));
        if (sel == 0 ? rv4 : rv5) rv_cnt++;
        if (sel == 0 ? done4 : done5) done_cnt++;
    end

    function automatic logic [7:0]  m_net();    return sel != 0 ? {3'b0, cur5} : {4'b0, cur4}; endfunction
    function automatic logic        m_busy();   return sel != 0 ? busy5 : busy4;               endfunction
    function automatic logic [15:0] m_rd();     return sel != 0 ? rd5 : rd4;                   endfunction
    function automatic logic        m_steady(); return sel != 0 ? steady5 : steady4;           endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole rounds at a time, each pick = LFSR index then first not-yet-updated slot
    task automatic model(input int r, input logic [7:0] ini, input logic [15:0] sd, input int n,
                         input bit so, input logic [7:0] fz, input int md,
                         output logic [7:0] fin, output int rounds, output bit st);
        logic [15:0] lf;
        logic [7:0]  s8, msk, full, nx;
        int          iw, v, ix;
        bit          chg;
        lf = (sd == 0) ? 16'h0001 : sd;
        full = 8'((1 << r) - 1);
        s8 = ini & full;
        iw = $clog2(r);
        rounds = 0;
        st = 0;
        exp_q.delete();
        while (rounds < n) begin
            msk = fz & full;
            chg = 0;
            while (msk != full) begin
                v  = int'(lf) % (1 << iw);
                ix = (v >= r) ? v - r : v;
                lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
                while (msk[ix]) ix = (ix + 1) % r;
                nx = stub(md, s8, r);
                if (nx[ix] != s8[ix]) chg = 1;
                s8[ix]  = nx[ix];
                msk[ix] = 1'b1;
                exp_q.push_back(ix);
            end
            rounds++;
            if (so && !chg) begin
                st = 1;
                break;
            end
        end
        fin = s8;
    endtask

    task automatic launch(int s, int md, logic [7:0] ini, logic [15:0] sd, logic [15:0] n,
                          logic so, logic [7:0] fz);
        sel = s; mode = md; init_s = ini; seed = sd; nr = n; sos = so; frz_s = fz;
        got_q.delete();
        rv_cnt = 0;
        done_cnt = 0;
        if (s != 0) start5 = 1'b1; else start4 = 1'b1;
        tick();
        start4 = 1'b0;
        start5 = 1'b0;
    endtask

    task automatic wait_done(string tag);
        int n = 0;
        while (m_busy() && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, ".finished"}, 32'(m_busy()), 32'd0);
    endtask

    task automatic run_check(string tag, int s, int md, logic [7:0] ini, logic [15:0] sd,
                             logic [15:0] n, logic so, logic [7:0] fz);
        logic [7:0] efin;
        int         erd;
        bit         est;
        int         r = (s != 0) ? 5 : 4;
        launch(s, md, ini, sd, n, so, fz);
        wait_done(tag);
        model(r, ini, sd, int'(n), so, fz, md, efin, erd, est);
        chk({tag, ".nupd"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, ".idx"}, got_q[i], exp_q[i]);
        chk({tag, ".net"}, 32'(m_net()), 32'(efin));
        chk({tag, ".rounds"}, 32'(m_rd()), erd);
        chk({tag, ".steady"}, 32'(m_steady()), 32'(est));
        chk({tag, ".ndone"}, done_cnt, 1);
        chk({tag, ".nround"}, rv_cnt, erd);
    endtask

    initial begin
        int q0[$];
        int sum, zeros;
        logic [3:0] snap;

        tick();
        tick();
        reset = 1'b0;
        chk("reset.outs4", {busy4, done4, rv4, upd4, steady4, cur4, rd4, idx4}, 0);
        chk("reset.outs5", {busy5, done5, rv5, upd5, steady5, cur5, rd5, idx5}, 0);

        run_check("ident", 0, 0, 8'b1010, 16'hACE1, 5, 1'b1, 8'h00);
        chk("ident.nupd4", got_q.size(), 4);
        chk("ident.net", 32'(cur4), 32'hA);
        chk("ident.rounds1", 32'(rd4), 1);
        chk("ident.steady1", 32'(steady4), 1);

        run_check("inv", 0, 1, 8'h00, 16'h1234, 3, 1'b1, 8'h00);
        chk("inv.nupd12", got_q.size(), 12);
        chk("inv.net", 32'(cur4), 32'hF);
        chk("inv.rounds3", 32'(rd4), 3);
        chk("inv.steady0", 32'(steady4), 0);
        for (int rr = 0; rr < 3; rr++) begin
            sum = 0;
            for (int k = 0; k < 4; k++) sum += 1 << got_q[rr * 4 + k];
            chk("inv.perm", sum, 15);
        end

        run_check("chain", 0, 2, 8'b0001, 16'hBEEF, 5, 1'b1, 8'b0001);
        zeros = 0;
        foreach (got_q[i]) if (got_q[i] == 0) zeros++;
        chk("chain.frozen", zeros, 0);
        chk("chain.net", 32'(cur4), 32'hF);
        chk("chain.le4", 32'(rd4 <= 16'd4), 1);

        run_check("seed0", 1, 3, 8'b10110, 16'h0000, 4, 1'b0, 8'h00);
        q0 = got_q;
        run_check("seed1", 1, 3, 8'b10110, 16'h0001, 4, 1'b0, 8'h00);
        chk("seed.len", q0.size(), got_q.size());
        for (int i = 0; i < q0.size() && i < got_q.size(); i++) chk("seed.same", got_q[i], q0[i]);

        run_check("vfold", 1, 0, 8'h00, 16'h0006, 1, 1'b0, 8'h00);
        chk("vfold.first", got_q[0], 1);

        run_check("wrap", 1, 0, 8'h00, 16'h8004, 1, 1'b0, 8'h00);
        chk("wrap.o0", got_q[0], 4);
        chk("wrap.o1", got_q[1], 1);
        chk("wrap.o2", got_q[2], 2);
        chk("wrap.o3", got_q[3], 0);
        chk("wrap.o4", got_q[4], 3);

        launch(0, 1, 8'h00, 16'h5A5A, 5, 1'b0, 8'h00);
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (upd4 && rv_cnt >= 1) break;
        end
        chk("abort.reached", 32'(upd4 && rv_cnt == 1), 1);
        abort = 1'b1;
        snap = cur4;
        tick();
        abort = 1'b0;
        chk("abort.busy", 32'(busy4), 0);
        chk("abort.net", 32'(cur4), 32'(snap));
        repeat (3) tick();
        chk("abort.nodone", done_cnt, 0);
        chk("abort.noround", rv_cnt, 1);
        chk("abort.hold", 32'(cur4), 32'(snap));
        launch(0, 1, 8'b0110, 16'h5A5A, 5, 1'b0, 8'h00);
        chk("restart.net", 32'(cur4), 32'h6);
        chk("restart.rounds", 32'(rd4), 0);
        wait_done("restart");
        chk("restart.rounds5", 32'(rd4), 5);

        launch(0, 0, 8'b1001, 16'h0001, 0, 1'b0, 8'h00);
        chk("zero.done", 32'(done4), 1);
        chk("zero.net", 32'(cur4), 32'h9);
        tick();
        chk("zero.idle", {busy4, done4}, 0);
        chk("zero.nupd", got_q.size(), 0);
        chk("zero.ndone", done_cnt, 1);

        launch(0, 1, 8'h00, 16'h0007, 20, 1'b0, 8'h00);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        chk("rst.outs", {busy4, done4, rv4, upd4, steady4, cur4, rd4, idx4}, 0);
        reset = 1'b0;
        repeat (3) tick();
        chk("rst.nodone", done_cnt, 0);

        for (int t = 0; t < 20; t++) begin
            run_check("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      8'($urandom), 16'($urandom), 16'($urandom_range(1, 6)),
                      1'($urandom), 8'($urandom & $urandom & $urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
